alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_muldiv.sv | 77 +++++++
 rtl/alu_seq.sv | 136 +++++++++++++
 tb/tb_alu_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared CPU definitions: ALU op codes, sequencer state encoding and result types.
// The accumulator controller imports the same package so both agree on encodings.
package alu_seq_pkg;

    localparam int DATA_W   = 8;
    localparam int MD_ITERS = 8;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_INC   = 4'h6,
        OP_DEC   = 4'h7,
        OP_SHL   = 4'h8,
        OP_SHR   = 4'h9,
        OP_PASSB = 4'hA,
        OP_MUL   = 4'hB,
        OP_DIV   = 4'hC
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              c;
        logic              v;
    } alu_out_t;

    function automatic logic is_multi(logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the accumulator controller (master) and alu_seq (slave).
interface alu_seq_if;
    import alu_seq_pkg::*;

    logic              start;
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] result_hi;
    logic              busy;
    logic              done;
    logic              flag_z;
    logic              flag_n;
    logic              flag_c;
    logic              flag_v;

    modport master (
        output start, op, a, b,
        input  result, result_hi, busy, done, flag_z, flag_n, flag_c, flag_v
    );

    modport slave (
        input  start, op, a, b,
        output result, result_hi, busy, done, flag_z, flag_n, flag_c, flag_v
    );

endinterface

// File: rtl/alu_muldiv.sv
// Iterative 8-cycle shift-add multiplier / restoring divider sharing one hi:lo register pair.
// done is raised during the last iteration; res_lo/res_hi then carry that iteration's outcome.
module alu_muldiv
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] res_lo,
    output logic [DATA_W-1:0] res_hi,
    output logic              div0
);

    logic              run;
    logic              mode_div;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] hi_nx;
    logic [DATA_W-1:0] lo_nx;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   trial;

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    // Multiply: lo holds the multiplier, the product shifts right through hi:lo.
    always_comb begin
        sum    = '0;
        rem_sh = '0;
        trial  = '0;
        hi_nx  = hi;
        lo_nx  = lo;
        if (mode_div) begin
            rem_sh = {hi, lo[DATA_W-1]};
            trial  = rem_sh - {1'b0, opnd};
            lo_nx  = {lo[DATA_W-2:0], ~trial[DATA_W]};
            hi_nx  = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
        end else begin
            sum            = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
            {hi_nx, lo_nx} = {sum, lo[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            mode_div <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
        end else if (start) begin
            run      <= 1'b1;
            mode_div <= is_div;
            cnt      <= '0;
            hi       <= '0;
            lo       <= is_div ? a : b;
            opnd     <= is_div ? b : a;
        end else if (run) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 3'd1;
            if (done) run <= 1'b0;
        end
    end

    assign done   = run && (cnt == 3'(MD_ITERS - 1));
    assign res_lo = lo_nx;
    assign res_hi = hi_nx;
    assign div0   = (opnd == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequenced accumulator ALU: single-cycle ops complete on the accept edge,
// MUL/DIV are handed to alu_muldiv and complete eight edges later.
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    state_e            state;
    state_e            state_nx;
    logic              accept;
    logic              md_start;
    logic              md_done;
    logic              md_div0;
    logic [DATA_W-1:0] md_lo;
    logic [DATA_W-1:0] md_hi;
    alu_out_t          sc;

    function automatic alu_out_t alu_single(logic [3:0] op, logic [DATA_W-1:0] a,
                                            logic [DATA_W-1:0] b);
        alu_out_t                 o;
        logic [DATA_W:0]          wide;
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic signed [DATA_W-1:0] sr;
        o    = '0;
        wide = '0;
        sa   = signed'(a);
        sb   = signed'(b);
        case (op)
            OP_ADD:  wide  = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide  = {1'b0, a} - {1'b0, b};
            OP_INC:  wide  = {1'b0, a} + (DATA_W+1)'(1);
            OP_DEC:  wide  = {1'b0, a} - (DATA_W+1)'(1);
            OP_AND:  o.res = a & b;
            OP_OR:   o.res = a | b;
            OP_XOR:  o.res = a ^ b;
            OP_NOT:  o.res = ~a;
            OP_SHL:  begin o.res = {a[DATA_W-2:0], 1'b0}; o.c = a[DATA_W-1]; end
            OP_SHR:  begin o.res = {1'b0, a[DATA_W-1:1]}; o.c = a[0]; end
            default: o.res = b;
        endcase
        // Arithmetic ops take their result and carry/borrow from the widened sum.
        if (op == OP_ADD || op == OP_SUB || op == OP_INC || op == OP_DEC) begin
            o.res = wide[DATA_W-1:0];
            o.c   = wide[DATA_W];
        end
        sr = signed'(o.res);
        case (op)
            OP_ADD:  o.v = (sa[DATA_W-1] == sb[DATA_W-1]) && (sr[DATA_W-1] != sa[DATA_W-1]);
            OP_SUB:  o.v = (sa[DATA_W-1] != sb[DATA_W-1]) && (sr[DATA_W-1] != sa[DATA_W-1]);
            OP_INC:  o.v = !sa[DATA_W-1] && sr[DATA_W-1];
            OP_DEC:  o.v = sa[DATA_W-1] && !sr[DATA_W-1];
            default: o.v = 1'b0;
        endcase
        return o;
    endfunction

    assign accept   = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign md_start = accept && is_multi(bus.op);
    assign sc       = alu_single(bus.op, bus.a, bus.b);

    alu_muldiv u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (bus.op == OP_DIV),
        .a      (bus.a),
        .b      (bus.b),
        .done   (md_done),
        .res_lo (md_lo),
        .res_hi (md_hi),
        .div0   (md_div0)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                bus.done = (state == ST_DONE);
                state_nx = ST_IDLE;
                if (accept) begin
                    if (bus.op == OP_MUL)      state_nx = ST_MUL;
                    else if (bus.op == OP_DIV) state_nx = ST_DIV;
                    else                       state_nx = ST_DONE;
                end
            end
            ST_MUL, ST_DIV: begin
                bus.busy = 1'b1;
                if (md_done) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Result and flag registers change only on a completion edge and hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.flag_z    <= 1'b0;
            bus.flag_n    <= 1'b0;
            bus.flag_c    <= 1'b0;
            bus.flag_v    <= 1'b0;
        end else if (accept && !md_start) begin
            bus.result    <= sc.res;
            bus.result_hi <= '0;
            bus.flag_z    <= (sc.res == '0);
            bus.flag_n    <= sc.res[DATA_W-1];
            bus.flag_c    <= sc.c;
            bus.flag_v    <= sc.v;
        end else if (md_done) begin
            bus.result    <= md_lo;
            bus.result_hi <= md_hi;
            bus.flag_z    <= (md_lo == '0);
            bus.flag_n    <= md_lo[DATA_W-1];
            if (state == ST_MUL) begin
                bus.flag_c <= (md_hi != '0);
                bus.flag_v <= (md_hi != '0);
            end else begin
                bus.flag_c <= md_div0;
                bus.flag_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner vectors, randomized ops against
// an arithmetic reference model, busy-ignore, back-to-back and mid-operation reset.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_seq_if bus ();

    alu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {result, result_hi, z, n, c, v}.
    function automatic logic [19:0] obs();
        return {bus.result, bus.result_hi, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
    endfunction

    function automatic logic multi(input logic [3:0] o);
        return (o == OP_MUL) || (o == OP_DIV);
    endfunction

    // Reference model from the arithmetic definition of each op.
    function automatic logic [19:0] model(input logic [3:0] o, input logic [7:0] x,
                                          input logic [7:0] y);
        int ux, uy, sx, sy, s, ss;
        logic [7:0] r, h;
        logic c, v;
        ux = int'(x); uy = int'(y);
        sx = int'($signed(x)); sy = int'($signed(y));
        s = 0; ss = 0; h = 8'h00; c = 1'b0; v = 1'b0;
        case (o)
            OP_ADD: begin s = ux + uy; ss = sx + sy; c = (s > 255); v = (ss > 127) || (ss < -128); end
            OP_SUB: begin s = ux - uy; ss = sx - sy; c = (ux < uy); v = (ss > 127) || (ss < -128); end
            OP_INC: begin s = ux + 1;  ss = sx + 1;  c = (s > 255); v = (ss > 127); end
            OP_DEC: begin s = ux - 1;  ss = sx - 1;  c = (ux == 0); v = (ss < -128); end
            OP_AND: s = int'(x & y);
            OP_OR:  s = int'(x | y);
            OP_XOR: s = int'(x ^ y);
            OP_NOT: s = 255 - ux;
            OP_SHL: begin s = ux * 2; c = (ux >= 128); end
            OP_SHR: begin s = ux / 2; c = (ux % 2) == 1; end
            OP_MUL: begin
                s = ux * uy; h = 8'(s / 256);
                c = (s / 256) != 0; v = c;
            end
            OP_DIV: begin
                if (uy == 0) begin s = 255; h = x; c = 1'b1; end
                else begin s = ux / uy; h = 8'(ux % uy); end
            end
            default: s = uy;
        endcase
        r = s[7:0];
        return {r, h, (r == 8'h00), r[7], c, v};
    endfunction

    // Drives one request at a negedge and returns at the negedge where done is seen
    // (or when the cycle budget runs out). Operands are scrambled after the accept.
    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         output int cyc, output int bcnt);
        bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
        cyc = 0; bcnt = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a  = 8'($urandom);
            bus.b  = 8'($urandom);
            bus.op = 4'($urandom);
            cyc++;
            if (bus.busy) bcnt++;
        end while (!bus.done && cyc < 20);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0; bus.op = 4'h0; bus.a = 8'h00; bus.b = 8'h00;
        repeat (2) @(negedge clk);
        total++;
        if (obs() !== 20'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got outs=%h busy=%b done=%b want outs=0 busy=0 done=0",
                     obs(), bus.busy, bus.done);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs() !== 20'h0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got outs=%h done=%b want outs=0 done=0", obs(), bus.done);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [6];
        logic [7:0]  xs  [6];
        logic [7:0]  ys  [6];
        logic [19:0] ex  [6];
        int cyc, bcnt, lat, bsy;
        ops = '{OP_ADD, OP_SUB, OP_SUB, OP_MUL, OP_DIV, OP_DIV};
        xs  = '{8'h7F, 8'h00, 8'h05, 8'hFF, 8'h64, 8'h33};
        ys  = '{8'h01, 8'h01, 8'h05, 8'hFF, 8'h07, 8'h00};
        ex  = '{{8'h80, 8'h00, 4'b0101}, {8'hFF, 8'h00, 4'b0110}, {8'h00, 8'h00, 4'b1000},
                {8'h01, 8'hFE, 4'b0011}, {8'h0E, 8'h02, 4'b0000}, {8'hFF, 8'h33, 4'b0110}};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], xs[i], ys[i], cyc, bcnt);
            lat = multi(ops[i]) ? 9 : 1;
            bsy = multi(ops[i]) ? 8 : 0;
            total++;
            if (obs() !== ex[i]) begin
                bad++;
                $display("FAIL directed_%0d_value: got %h want %h", i, obs(), ex[i]);
            end
            total++;
            if (cyc !== lat || bcnt !== bsy) begin
                bad++;
                $display("FAIL directed_%0d_timing: got done_at=%0d busy_cycles=%0d want %0d/%0d",
                         i, cyc, bcnt, lat, bsy);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [7:0]  x, y;
        logic [19:0] exp_v, held;
        int cyc, bcnt;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            x = 8'($urandom);
            y = (i % 10 == 3) ? 8'h00 : 8'($urandom);
            exp_v = model(o, x, y);
            issue(o, x, y, cyc, bcnt);
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL random_%0d_op%0h_value: a=%h b=%h got %h want %h", i, o, x, y, obs(), exp_v);
            end
            total++;
            if (cyc !== (multi(o) ? 9 : 1) || bcnt !== (multi(o) ? 8 : 0)) begin
                bad++;
                $display("FAIL random_%0d_timing: got done_at=%0d busy_cycles=%0d op=%0h", i, cyc, bcnt, o);
            end
            held = obs();
            @(negedge clk);
            total++;
            if (obs() !== held || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL random_%0d_hold: got outs=%h done=%b busy=%b want outs=%h done=0 busy=0",
                         i, obs(), bus.done, bus.busy, held);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        logic [19:0] exp_v;
        exp_v = model(OP_MUL, 8'h0F, 8'h11);
        bus.op = OP_MUL; bus.a = 8'h0F; bus.b = 8'h11; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; cyc = 1;
        @(negedge clk); cyc = 2;
        bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h01; bus.start = 1'b1;
        @(negedge clk); cyc = 3; bus.start = 1'b0;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (obs() !== exp_v || cyc !== 9) begin
            bad++;
            $display("FAIL busy_ignore: got outs=%h done_at=%0d want outs=%h done_at=9", obs(), cyc, exp_v);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || obs() !== exp_v) begin
            bad++;
            $display("FAIL busy_ignore_after: got done=%b busy=%b outs=%h want 0/0/%h",
                     bus.done, bus.busy, obs(), exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x1, y1, x2, y2, x3, y3;
        int cyc;
        x1 = 8'($urandom); y1 = 8'($urandom);
        x2 = 8'($urandom); y2 = 8'($urandom);
        x3 = 8'($urandom); y3 = 8'($urandom);
        bus.op = OP_ADD; bus.a = x1; bus.b = y1; bus.start = 1'b1;
        @(negedge clk);
        total++;
        if (bus.done !== 1'b1 || obs() !== model(OP_ADD, x1, y1)) begin
            bad++;
            $display("FAIL b2b_add: got done=%b outs=%h want 1/%h", bus.done, obs(), model(OP_ADD, x1, y1));
        end
        bus.op = OP_MUL; bus.a = x2; bus.b = y2;
        @(negedge clk);
        bus.start = 1'b0; cyc = 1;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_mul_accept: got busy=%b want 1", bus.busy);
        end
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (obs() !== model(OP_MUL, x2, y2) || cyc !== 9) begin
            bad++;
            $display("FAIL b2b_mul: got outs=%h done_at=%0d want %h/9", obs(), cyc, model(OP_MUL, x2, y2));
        end
        bus.op = OP_SUB; bus.a = x3; bus.b = y3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b1 || obs() !== model(OP_SUB, x3, y3)) begin
            bad++;
            $display("FAIL b2b_sub: got done=%b outs=%h want 1/%h", bus.done, obs(), model(OP_SUB, x3, y3));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, bcnt, dones;
        issue(OP_ADD, 8'h10, 8'h20, cyc, bcnt);
        bus.op = OP_MUL; bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (obs() !== 20'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_clear: got outs=%h busy=%b done=%b want 0/0/0", obs(), bus.busy, bus.done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        total++;
        if (dones !== 0 || obs() !== 20'h0) begin
            bad++;
            $display("FAIL reset_mid_abort: got stray_cycles=%0d outs=%h want 0/0", dones, obs());
        end
        issue(OP_ADD, 8'h02, 8'h03, cyc, bcnt);
        total++;
        if (bus.result !== 8'h05 || cyc !== 1) begin
            bad++;
            $display("FAIL reset_mid_restart: got result=%h done_at=%0d want 05/1", bus.result, cyc);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
